// File: rtl/bcd_seq.sv
//============================================================================
// Module   : bcd_seq
// Purpose  : Sequential binary-to-BCD converter (double-dabble), one shift
//            per clock, start/busy/done handshake, overflow saturation.
// Options  : define BCD_SEQ_SIGN_EN for two's-complement input and sign_o.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
`ifdef BCD_SEQ_SIGN_EN
    output logic                  sign_o,
`endif
    output logic                  ovf_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   operand_q, operand_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_digits_sh;
    logic [BIN_W-1:0]   w_operand_sh;
    logic               w_sticky_sh;
    logic [BIN_W-1:0]   w_load;
    logic               w_accept;

`ifdef BCD_SEQ_SIGN_EN
    logic               sign_q, sign_d;
    logic               sgn_op_q, sgn_op_d;

    // Negating the most negative value yields 2^(BIN_W-1), which is the
    // correct magnitude when the result is read as unsigned.
    assign w_load = bin_i[BIN_W-1] ? (~bin_i + 1'b1) : bin_i;
`else
    assign w_load = bin_i;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit_adj
        assign w_adj[4*i +: 4] = (digits_q[4*i +: 4] > 4'd4) ?
                                 (digits_q[4*i +: 4] + 4'd3) :
                                 digits_q[4*i +: 4];
    end

    assign w_digits_sh  = {w_adj[BCD_W-2:0], operand_q[BIN_W-1]};
    assign w_operand_sh = {operand_q[BIN_W-2:0], 1'b0};
    assign w_sticky_sh  = sticky_q | w_adj[BCD_W-1];

    assign w_accept = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        digits_d  = digits_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
`ifdef BCD_SEQ_SIGN_EN
        sign_d    = sign_q;
        sgn_op_d  = sgn_op_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    state_d   = ST_SHIFT;
                    operand_d = w_load;
                    digits_d  = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = CNT_W'(BIN_W - 1);
`ifdef BCD_SEQ_SIGN_EN
                    sgn_op_d  = bin_i[BIN_W-1];
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                operand_d = w_operand_sh;
                digits_d  = w_digits_sh;
                sticky_d  = w_sticky_sh;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    ovf_d   = w_sticky_sh;
                    bcd_d   = w_sticky_sh ? {DIGITS{4'h9}} : w_digits_sh;
`ifdef BCD_SEQ_SIGN_EN
                    sign_d  = sgn_op_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            operand_q <= '0;
            digits_q  <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_SEQ_SIGN_EN
            sign_q    <= 1'b0;
            sgn_op_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            digits_q  <= digits_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
`ifdef BCD_SEQ_SIGN_EN
            sign_q    <= sign_d;
            sgn_op_q  <= sgn_op_d;
`endif
        end
    end

    assign busy_o = (state_q == ST_SHIFT);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;
`ifdef BCD_SEQ_SIGN_EN
    assign sign_o = sign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_seq.sv
//============================================================================
// Module   : tb_bcd_seq
// Purpose  : Scoreboard bench for bcd_seq (12-bit input, 4 and 3 digits).
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_start = 1'b0;
    logic [11:0] a_bin   = '0;
    logic        a_busy, a_done, a_ovf;
    logic [15:0] a_bcd;
    logic        b_start = 1'b0;
    logic [11:0] b_bin   = '0;
    logic        b_busy, b_done, b_ovf;
    logic [11:0] b_bcd;
`ifdef BCD_SEQ_SIGN_EN
    logic        a_sign, b_sign;
`endif

    bcd_seq #(.BIN_W(12), .DIGITS(4)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .bin_i(a_bin),
        .busy_o(a_busy), .done_o(a_done), .bcd_o(a_bcd),
`ifdef BCD_SEQ_SIGN_EN
        .sign_o(a_sign),
`endif
        .ovf_o(a_ovf)
    );

    bcd_seq #(.BIN_W(12), .DIGITS(3)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .bin_i(b_bin),
        .busy_o(b_busy), .done_o(b_done), .bcd_o(b_bcd),
`ifdef BCD_SEQ_SIGN_EN
        .sign_o(b_sign),
`endif
        .ovf_o(b_ovf)
    );

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic        sgn;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic a_prev = 1'b0;
    logic b_prev = 1'b0;

    logic [11:0] held_bin [3] = '{12'd1, 12'd2047, 12'd512};
    logic [15:0] held_exp [3] = '{16'h0001, 16'h2047, 16'h0512};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare whenever a DUT presents done.
    always @(negedge clk) begin
        if (rst) begin
            a_prev = 1'b0;
        end else begin
            if (a_done) begin
                chk("a_done_twice", {31'd0, a_prev}, 32'd0);
                chk("a_busy_at_done", {31'd0, a_busy}, 32'd0);
                chk("a_done_expected", (qa.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    chk("a_bcd", {16'd0, a_bcd}, {16'd0, ea.bcd});
                    chk("a_ovf", {31'd0, a_ovf}, {31'd0, ea.ovf});
                    chk("a_done_cycle", cyc, ea.cyc);
`ifdef BCD_SEQ_SIGN_EN
                    chk("a_sign", {31'd0, a_sign}, {31'd0, ea.sgn});
`endif
                end
            end
            a_prev = a_done;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            b_prev = 1'b0;
        end else begin
            if (b_done) begin
                chk("b_done_twice", {31'd0, b_prev}, 32'd0);
                chk("b_done_expected", (qb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    chk("b_bcd", {20'd0, b_bcd}, {16'd0, eb.bcd});
                    chk("b_ovf", {31'd0, b_ovf}, {31'd0, eb.ovf});
                    chk("b_done_cycle", cyc, eb.cyc);
`ifdef BCD_SEQ_SIGN_EN
                    chk("b_sign", {31'd0, b_sign}, {31'd0, eb.sgn});
`endif
                end
            end
            b_prev = b_done;
        end
    end

    // One-cycle start pulse; returns one cycle after the accepting edge.
    task automatic go(input bit on_b, input logic [11:0] v, input logic [15:0] e_bcd,
                      input logic e_ovf, input logic e_sgn, input bit push);
        @(posedge clk); #1;
        if (on_b) begin
            b_bin = v; b_start = 1'b1;
            if (push) qb.push_back('{bcd: e_bcd, ovf: e_ovf, sgn: e_sgn, cyc: cyc + 13});
        end else begin
            a_bin = v; a_start = 1'b1;
            if (push) qa.push_back('{bcd: e_bcd, ovf: e_ovf, sgn: e_sgn, cyc: cyc + 13});
        end
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (qa.size() + qb.size()) > 0; i++) @(posedge clk);
        chk("drain_timeout", qa.size() + qb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_bcd_a", {16'd0, a_bcd}, 32'd0);
        chk("rst_ovf_a", {31'd0, a_ovf}, 32'd0);
        chk("rst_bcd_b", {20'd0, b_bcd}, 32'd0);
        chk("rst_ovf_b", {31'd0, b_ovf}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full-scale operand, plus busy length.
`ifdef BCD_SEQ_SIGN_EN
        go(1'b0, 12'd4095, 16'h0001, 1'b0, 1'b1, 1'b1);
`else
        go(1'b0, 12'd4095, 16'h4095, 1'b0, 1'b0, 1'b1);
`endif
        nb = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            nb += int'(a_busy);
        end
        chk("a_busy_cycles", nb, 32'd12);
        drain();

        // Three-digit saturation boundary.
        go(1'b1, 12'd1000, 16'h0999, 1'b1, 1'b0, 1'b1); drain();
        go(1'b1, 12'd999,  16'h0999, 1'b0, 1'b0, 1'b1); drain();
        go(1'b1, 12'd1234, 16'h0999, 1'b1, 1'b0, 1'b1); drain();
        go(1'b1, 12'd58,   16'h0058, 1'b0, 1'b0, 1'b1); drain();

        go(1'b0, 12'd0, 16'h0000, 1'b0, 1'b0, 1'b1); drain();

        // Start held high: restart on every DONE cycle with a new operand.
        @(posedge clk); #1;
        a_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_bin = held_bin[i];
            qa.push_back('{bcd: held_exp[i], ovf: 1'b0, sgn: 1'b0, cyc: cyc + 13});
            repeat (13) @(posedge clk);
            #1;
        end
        a_start = 1'b0;
        drain();

        // Start during SHIFT must be ignored.
        go(1'b0, 12'd1234, 16'h1234, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        a_bin = 12'd42; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        drain();
        repeat (20) @(posedge clk);

        // Reset mid-conversion.
        go(1'b0, 12'd1500, 16'h1500, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("midrst_busy", {31'd0, a_busy}, 32'd0);
        chk("midrst_bcd", {16'd0, a_bcd}, 32'd0);
        chk("midrst_done", {31'd0, a_done}, 32'd0);
        chk("midrst_bcd_b", {20'd0, b_bcd}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        go(1'b0, 12'd7, 16'h0007, 1'b0, 1'b0, 1'b1); drain();

`ifdef BCD_SEQ_SIGN_EN
        go(1'b0, 12'h800, 16'h2048, 1'b0, 1'b1, 1'b1); drain();
        go(1'b0, 12'hFFF, 16'h0001, 1'b0, 1'b1, 1'b1); drain();
        go(1'b0, 12'h005, 16'h0005, 1'b0, 1'b0, 1'b1); drain();
        go(1'b1, 12'hC18, 16'h0999, 1'b1, 1'b1, 1'b1); drain();
`endif

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
